// File: rtl/enum_swap_arbiter_if.sv
// enum_swap_arbiter_if
//   Request/response bundle between NREQ enum producers and the shared
//   enum-swap arbiter.
//   req_valid [NREQ]  requester i holds a token
//   req_tok   [NREQ]  token of requester i (test_t encoding)
//   req_ready [NREQ]  one-hot grant, combinational while idle
//   rsp_valid [NREQ]  one-hot: owner of the pending result
//   rsp_tok           swapped token, meaningful while rsp_valid != 0
//   rsp_ready [NREQ]  requester i accepts its response
//   master = requester side, slave = arbiter side.
interface enum_swap_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_tok;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] rsp_valid;
  logic            rsp_tok;
  logic [NREQ-1:0] rsp_ready;

  modport master (
    output req_valid, req_tok, rsp_ready,
    input  req_ready, rsp_valid, rsp_tok
  );

  modport slave (
    input  req_valid, req_tok, rsp_ready,
    output req_ready, rsp_valid, rsp_tok
  );
endinterface

// File: rtl/enum_swap_arbiter.sv
// enum_swap_arbiter
//   Round-robin arbiter in front of a single enum-swap stage. One token is in
//   flight at a time: it is accepted in IDLE, spends LAT cycles in WAIT and is
//   held in RESP until its owner takes it. The swap is TEST_1 <-> TEST_2.
//   Parameters: NREQ (2..8) requesters, LAT (1..4) swap latency,
//               COUNT_INIT preload for swap_count (0 in normal use).
//   Ports: clk, rst_n (async, active low)
//          bus        slave side of enum_swap_arbiter_if
//          busy       high outside IDLE
//          grant_id   current or last owner
//          swap_count completed transactions, wraps at 16 bits
module enum_swap_arbiter #(
  parameter int          NREQ       = 4,
  parameter int          LAT        = 2,
  parameter logic [15:0] COUNT_INIT = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  enum_swap_arbiter_if.slave  bus,
  output logic                busy,
  output logic [2:0]          grant_id,
  output logic [15:0]         swap_count
);

  typedef enum logic {TEST_1 = 1'b0, TEST_2 = 1'b1} test_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic test_t swap_tok(input test_t t);
    return (t == TEST_1) ? TEST_2 : TEST_1;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  ptr_q;    // last served requester; search starts one above
  logic [2:0]  owner_q;
  logic [1:0]  cnt_q;    // remaining WAIT cycles minus one
  test_t       tok_q;
  logic [15:0] count_q;

  // Requests widened to 8 bits so a 3-bit index never runs off the vector.
  logic [7:0]  valid_ext, tok_ext, rready_ext;
  logic [2:0]  cand;
  logic [2:0]  winner;
  logic        found;
  logic        accept;
  logic        done;

  assign valid_ext  = 8'(bus.req_valid);
  assign tok_ext    = 8'(bus.req_tok);
  assign rready_ext = 8'(bus.rsp_ready);

  // Rotating priority search: ptr+1, ptr+2, ... wrapping at NREQ.
  // NOTE: every signal driven in always_comb gets a default before any
  // branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 3'((int'(ptr_q) + k) % NREQ);
      if (!found && valid_ext[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: if (found) begin
        accept  = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (cnt_q == '0) state_d = RESP;
      RESP: if (rready_ext[owner_q]) begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= 3'(NREQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      tok_q   <= TEST_1;
      count_q <= COUNT_INIT;
    end else begin
      if (accept) begin
        tok_q   <= swap_tok(test_t'(tok_ext[winner]));
        owner_q <= winner;
        ptr_q   <= winner;
        cnt_q   <= 2'(LAT - 1);
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if (done) count_q <= count_q + 16'd1;
    end
  end

  // req_ready is the only combinational output; it is gated by rst_n so
  // reset forces it low even while requests are present.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (accept && rst_n)    bus.req_ready = NREQ'(8'd1 << winner);
    if (state_q == RESP)    bus.rsp_valid = NREQ'(8'd1 << owner_q);
  end

  assign bus.rsp_tok = tok_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = owner_q;
  assign swap_count  = count_q;

endmodule
